run_sequencer: RTL and testbench

Mission-level controller that sequences the tracking/u-turn datapath through a complete run. It raises one enable at a time (track, brake, u-turn, reverse, forward-brake) and waits for that step's completion flag. Between steps it holds a quiet gap with every enable low. It counts laps, enforces a per-step timeout and reports busy/done/fault to the top level. It sits between the board start/abort inputs and the track/u-turn block, which runs on the same 1 MHz clock.

---
 rtl/run_sequencer_pkg.sv | 54 +++++
 rtl/run_sequencer_step_timer.sv | 31 +++
 rtl/run_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_run_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer: state encodings, LED step codes
// and the 1 us timebase constants also used by the track/u-turn block.
package run_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_TRACK   = 4'd1,
    S_BRAKE   = 4'd2,
    S_UTURN   = 4'd3,
    S_REVERSE = 4'd4,
    S_FBRAKE  = 4'd5,
    S_GAP     = 4'd6,
    S_DONE    = 4'd7,
    S_FAULT   = 4'd8
  } state_t;

  localparam logic [2:0] STEP_IDLE    = 3'd0;
  localparam logic [2:0] STEP_TRACK   = 3'd1;
  localparam logic [2:0] STEP_BRAKE   = 3'd2;
  localparam logic [2:0] STEP_UTURN   = 3'd3;
  localparam logic [2:0] STEP_REVERSE = 3'd4;
  localparam logic [2:0] STEP_FBRAKE  = 3'd5;
  localparam logic [2:0] STEP_GAP     = 3'd6;
  localparam logic [2:0] STEP_END     = 3'd7;

  localparam int unsigned CYCLES_PER_US   = 1;
  localparam int unsigned CYCLES_PER_MS   = 1000 * CYCLES_PER_US;
  localparam int unsigned CYCLES_PER_S    = 1000 * CYCLES_PER_MS;
  localparam int unsigned GAP_DEFAULT     = CYCLES_PER_MS;
  localparam int unsigned TIMEOUT_DEFAULT = 20 * CYCLES_PER_S;
  localparam int unsigned TO_W_DEFAULT    = 25;

  // DONE and FAULT share the LED code; the fault output tells them apart.
  function automatic logic [2:0] step_code(input state_t s);
    logic [2:0] c;
    c = STEP_IDLE;
    case (s)
      S_TRACK:         c = STEP_TRACK;
      S_BRAKE:         c = STEP_BRAKE;
      S_UTURN:         c = STEP_UTURN;
      S_REVERSE:       c = STEP_REVERSE;
      S_FBRAKE:        c = STEP_FBRAKE;
      S_GAP:           c = STEP_GAP;
      S_DONE, S_FAULT: c = STEP_END;
      default:         c = STEP_IDLE;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/run_sequencer_step_timer.sv
// Loadable down-counter: load wins over decrement, clear wins over load.
// expired is high whenever the count sits at zero.
module step_timer #(
  parameter int unsigned W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/run_sequencer.sv
// Mission sequencer: walks the datapath through track/brake/u-turn laps and the
// final reverse/forward-brake, one enable at a time, with quiet gaps between.
//
//   state   | meaning
//   IDLE    | waiting for a start edge, nothing enabled
//   TRACK   | line tracking until end_of_track
//   BRAKE   | braking until brake_finished
//   UTURN   | u-turn until uturn_finished, then lap count advances
//   REVERSE | reversing until reverse_finished
//   FBRAKE  | forward brake until fbrake_finished
//   GAP     | all enables low, wait GAP cycles and for all flags to clear
//   DONE    | run completed
//   FAULT   | a step or gap exceeded STEP_TIMEOUT
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int unsigned LAPS         = 2,
  parameter int unsigned STEP_TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned GAP          = GAP_DEFAULT,
  parameter int unsigned TO_W         = TO_W_DEFAULT
) (
  input  logic       clkus,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       end_of_track,
  input  logic       uturn_finished,
  input  logic       brake_finished,
  input  logic       reverse_finished,
  input  logic       fbrake_finished,
  output logic       en_tracking,
  output logic       en_uturn,
  output logic       en_brake,
  output logic       en_reverse,
  output logic       en_fbrake,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] lap_cnt,
  output logic [2:0] step
);

  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(STEP_TIMEOUT - 1);
  localparam logic [TO_W-1:0] GAP_LOAD = TO_W'(GAP - 1);
  localparam logic [3:0]      LAPS_L   = 4'(LAPS);

  state_t     state, state_nx, ret, ret_nx;
  logic [3:0] lap_nx;
  logic       start_low_q, start_rise;
  logic       gap_expired, to_expired, flags_clear, in_step, entering;
  logic       en_tracking_d, en_uturn_d, en_brake_d, en_reverse_d, en_fbrake_d;
  logic       busy_d, done_d, fault_d;
  logic [2:0] step_d;

  // start_low_q resets to 0, so a start held high through reset is not an edge
  assign start_rise  = start & start_low_q;
  assign flags_clear = ~(end_of_track | uturn_finished | brake_finished |
                         reverse_finished | fbrake_finished);
  assign in_step     = state inside {S_TRACK, S_BRAKE, S_UTURN, S_REVERSE, S_FBRAKE};
  assign entering    = (state_nx != state);

  step_timer #(.W(TO_W)) u_gap_timer (
    .clk      (clkus),
    .rst      (rst),
    .clear    (abort),
    .load     (entering && (state_nx == S_GAP)),
    .en       (state == S_GAP),
    .load_val (GAP_LOAD),
    .expired  (gap_expired)
  );

  // In GAP the timeout only runs once the quiet period is over, bounding the flag-clear wait.
  step_timer #(.W(TO_W)) u_timeout_timer (
    .clk      (clkus),
    .rst      (rst),
    .clear    (abort),
    .load     (entering),
    .en       (in_step || ((state == S_GAP) && gap_expired)),
    .load_val (TO_LOAD),
    .expired  (to_expired)
  );

  always_ff @(posedge clkus or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ret         <= S_IDLE;
      lap_cnt     <= '0;
      start_low_q <= 1'b0;
      en_tracking <= 1'b0;
      en_uturn    <= 1'b0;
      en_brake    <= 1'b0;
      en_reverse  <= 1'b0;
      en_fbrake   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      step        <= STEP_IDLE;
    end else begin
      state       <= state_nx;
      ret         <= ret_nx;
      lap_cnt     <= lap_nx;
      start_low_q <= ~start;
      en_tracking <= en_tracking_d;
      en_uturn    <= en_uturn_d;
      en_brake    <= en_brake_d;
      en_reverse  <= en_reverse_d;
      en_fbrake   <= en_fbrake_d;
      busy        <= busy_d;
      done        <= done_d;
      fault       <= fault_d;
      step        <= step_d;
    end
  end

  // Completion flags are tested before the timeout so a flag on the expiry cycle wins.
  always_comb begin
    state_nx = state;
    ret_nx   = ret;
    lap_nx   = lap_cnt;
    case (state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start_rise) begin
          state_nx = S_TRACK;
          lap_nx   = '0;
        end
      end
      S_TRACK: begin
        if (end_of_track) begin
          state_nx = S_GAP;
          ret_nx   = S_BRAKE;
        end else if (to_expired) begin
          state_nx = S_FAULT;
        end
      end
      S_BRAKE: begin
        if (brake_finished) begin
          state_nx = S_GAP;
          ret_nx   = S_UTURN;
        end else if (to_expired) begin
          state_nx = S_FAULT;
        end
      end
      S_UTURN: begin
        if (uturn_finished) begin
          lap_nx   = sat_inc4(lap_cnt);
          state_nx = S_GAP;
          ret_nx   = (lap_nx < LAPS_L) ? S_TRACK : S_REVERSE;
        end else if (to_expired) begin
          state_nx = S_FAULT;
        end
      end
      S_REVERSE: begin
        if (reverse_finished) begin
          state_nx = S_GAP;
          ret_nx   = S_FBRAKE;
        end else if (to_expired) begin
          state_nx = S_FAULT;
        end
      end
      S_FBRAKE: begin
        if (fbrake_finished) begin
          state_nx = S_GAP;
          ret_nx   = S_DONE;
        end else if (to_expired) begin
          state_nx = S_FAULT;
        end
      end
      S_GAP: begin
        if (gap_expired) begin
          if (flags_clear) begin
            state_nx = ret;
          end else if (to_expired) begin
            state_nx = S_FAULT;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) begin
      state_nx = S_IDLE;
      lap_nx   = lap_cnt;
    end
  end

  always_comb begin
    en_tracking_d = 1'b0;
    en_uturn_d    = 1'b0;
    en_brake_d    = 1'b0;
    en_reverse_d  = 1'b0;
    en_fbrake_d   = 1'b0;
    case (state_nx)
      S_TRACK:   en_tracking_d = 1'b1;
      S_BRAKE:   en_brake_d    = 1'b1;
      S_UTURN:   en_uturn_d    = 1'b1;
      S_REVERSE: en_reverse_d  = 1'b1;
      S_FBRAKE:  en_fbrake_d   = 1'b1;
      default:   ;
    endcase
    busy_d  = !(state_nx inside {S_IDLE, S_DONE, S_FAULT});
    done_d  = (state_nx == S_DONE);
    fault_d = (state_nx == S_FAULT);
    step_d  = step_code(state_nx);
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: a responder answers each enable with its flag,
// a table run and random runs are compared with the expected run shape.
module tb_run_sequencer;

  localparam int LAPS = 2;
  localparam int GAP  = 4;
  localparam int TMO  = 50;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       end_of_track, uturn_finished, brake_finished, reverse_finished, fbrake_finished;
  logic       en_tracking, en_uturn, en_brake, en_reverse, en_fbrake;
  logic       busy, done, fault;
  logic [3:0] lap_cnt;
  logic [2:0] step;

  int checks = 0;
  int errors = 0;

  run_sequencer #(.LAPS(LAPS), .STEP_TIMEOUT(TMO), .GAP(GAP), .TO_W(8)) dut (
    .clkus            (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .end_of_track     (end_of_track),
    .uturn_finished   (uturn_finished),
    .brake_finished   (brake_finished),
    .reverse_finished (reverse_finished),
    .fbrake_finished  (fbrake_finished),
    .en_tracking      (en_tracking),
    .en_uturn         (en_uturn),
    .en_brake         (en_brake),
    .en_reverse       (en_reverse),
    .en_fbrake        (en_fbrake),
    .busy             (busy),
    .done             (done),
    .fault            (fault),
    .lap_cnt          (lap_cnt),
    .step             (step)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int delay;
    int hold;
    int high;
    int gap;
    int lap;
  } vec_t;

  vec_t vec[8];

  function automatic int ens();
    return int'({en_tracking, en_brake, en_uturn, en_reverse, en_fbrake});
  endfunction

  // 1 track, 2 brake, 3 u-turn, 4 reverse, 5 forward brake
  function automatic int active_code();
    if (en_tracking) return 1;
    if (en_brake)    return 2;
    if (en_uturn)    return 3;
    if (en_reverse)  return 4;
    if (en_fbrake)   return 5;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_flag(input int code, input logic v);
    case (code)
      1: end_of_track     = v;
      2: brake_finished   = v;
      3: uturn_finished   = v;
      4: reverse_finished = v;
      5: fbrake_finished  = v;
      default: ;
    endcase
  endtask

  task automatic wait_en(output int code);
    int n;
    n    = 0;
    code = active_code();
    while (code == 0 && n < 100) begin
      @(negedge clk);
      n++;
      code = active_code();
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered on the first negedge where an enable is visible; leaves on the
  // negedge where the next enable (or done/fault) is visible.
  task automatic do_step(input int delay, input int hold,
                         output int code, output int high, output int gap);
    int n;
    code = active_code();
    high = 1;
    for (int k = 1; k <= delay; k++) begin
      @(negedge clk);
      if (active_code() == code) high++;
    end
    set_flag(code, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (active_code() == code) high++;
    end while (active_code() == code && n < 100);
    gap = 0;
    while (active_code() == 0 && !done && !fault && gap < 200) begin
      if (gap == hold) set_flag(code, 1'b0);
      gap++;
      @(negedge clk);
    end
    set_flag(code, 1'b0);
  endtask

  function automatic int exp_gap(input int hold);
    return (hold + 1 > GAP) ? hold + 1 : GAP;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones(ens()) > 1) begin
        errors++;
        $display("FAIL onehot: enables=%05b, expected at most one high", ens());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, expected run to complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int code, high, gap, lap_model, d, h;
    int seq[$];

    vec[0] = '{1, 5, 0, 6, 4,  0};
    vec[1] = '{2, 5, 9, 6, 10, 0};
    vec[2] = '{3, 5, 0, 6, 4,  1};
    vec[3] = '{1, 1, 2, 2, 4,  1};
    vec[4] = '{2, 7, 4, 8, 5,  1};
    vec[5] = '{3, 3, 0, 4, 4,  2};
    vec[6] = '{4, 5, 0, 6, 4,  2};
    vec[7] = '{5, 2, 3, 3, 4,  2};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    end_of_track = 1'b0; uturn_finished = 1'b0; brake_finished = 1'b0;
    reverse_finished = 1'b0; fbrake_finished = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_enables", ens(), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_lap", int'(lap_cnt), 0);
    chk("rst_step", int'(step), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_step", int'(step), 0);

    // table-driven full run, including a brake flag held past the gap
    start_run();
    wait_en(code);
    chk("tbl_busy", int'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl%0d_code", i), active_code(), vec[i].code);
      chk($sformatf("tbl%0d_led", i), int'(step), vec[i].code);
      do_step(vec[i].delay, vec[i].hold, code, high, gap);
      chk($sformatf("tbl%0d_high", i), high, vec[i].high);
      chk($sformatf("tbl%0d_gap", i), gap, vec[i].gap);
      chk($sformatf("tbl%0d_lap", i), int'(lap_cnt), vec[i].lap);
    end
    chk("tbl_done", int'(done), 1);
    chk("tbl_busy_end", int'(busy), 0);
    chk("tbl_fault", int'(fault), 0);
    chk("tbl_step_end", int'(step), 7);

    // random runs against the expected run shape
    for (int r = 0; r < 5; r++) begin
      seq.delete();
      for (int l = 0; l < LAPS; l++) begin
        seq.push_back(1); seq.push_back(2); seq.push_back(3);
      end
      seq.push_back(4); seq.push_back(5);
      lap_model = 0;
      start_run();
      wait_en(code);
      chk("rnd_lap_start", int'(lap_cnt), 0);
      chk("rnd_done_clr", int'(done), 0);
      foreach (seq[i]) begin
        d = int'($urandom_range(1, 12));
        h = int'($urandom_range(0, 8));
        chk("rnd_code", active_code(), seq[i]);
        do_step(d, h, code, high, gap);
        if (seq[i] == 3) lap_model++;
        chk("rnd_high", high, d + 1);
        chk("rnd_gap", gap, exp_gap(h));
        chk("rnd_lap", int'(lap_cnt), lap_model);
      end
      chk("rnd_done", int'(done), 1);
      chk("rnd_busy", int'(busy), 0);
    end

    // u-turn never completes: fault exactly TMO cycles after en_uturn rises
    start_run();
    wait_en(code);
    do_step(3, 0, code, high, gap);
    do_step(3, 0, code, high, gap);
    chk("to_code", active_code(), 3);
    repeat (TMO - 1) @(negedge clk);
    chk("to_fault_early", int'(fault), 0);
    chk("to_uturn_held", int'(en_uturn), 1);
    @(negedge clk);
    chk("to_fault", int'(fault), 1);
    chk("to_enables", ens(), 0);
    chk("to_busy", int'(busy), 0);
    chk("to_done", int'(done), 0);
    chk("to_step", int'(step), 7);

    // restart from FAULT, abort during REVERSE
    start_run();
    wait_en(code);
    chk("rs_lap", int'(lap_cnt), 0);
    chk("rs_fault_clr", int'(fault), 0);
    for (int i = 0; i < 6; i++) do_step(2, 0, code, high, gap);
    chk("ab_code", active_code(), 4);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_step", int'(step), 0);
    chk("ab_reverse", int'(en_reverse), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_lap", int'(lap_cnt), 2);

    // start edge together with abort: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("ab_start_enables", ens(), 0);
    chk("ab_start_busy", int'(busy), 0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    start_run();
    wait_en(code);
    chk("ab_restart_code", code, 1);
    chk("ab_restart_lap", int'(lap_cnt), 0);

    // end_of_track on the timeout expiry cycle: completion wins
    repeat (TMO - 1) @(negedge clk);
    end_of_track = 1'b1;
    @(negedge clk);
    chk("race_fault", int'(fault), 0);
    chk("race_step", int'(step), 6);
    chk("race_track", int'(en_tracking), 0);
    end_of_track = 1'b0;
    wait_en(code);
    chk("race_next", code, 2);

    // asynchronous reset mid-track, start held high through reset release
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start_run();
    wait_en(code);
    chk("ar_code", code, 1);
    #2;
    rst = 1'b1;
    start = 1'b1;
    #1;
    chk("ar_track_async", int'(en_tracking), 0);
    chk("ar_busy_async", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("ar_no_run", ens(), 0);
    chk("ar_no_busy", int'(busy), 0);
    chk("ar_step", int'(step), 0);
    start = 1'b0;
    @(negedge clk);
    start_run();
    wait_en(code);
    chk("ar_new_run", code, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
